// File: rtl/split_pkg.sv
// Shared definitions for the streaming split-constraint evaluator: mode codes,
// frame FSM states and accumulator width helper.
package split_pkg;

    localparam int MODE_TRUE        = 0;
    localparam int MODE_SUM_LE      = 1;
    localparam int MODE_PARITY_EVEN = 2;
    localparam int MODE_ALL_NZ      = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Wide enough that NUM_VARS full-scale values can never overflow the sum.
    function automatic int acc_width(input int num_vars, input int var_w);
        return var_w + $clog2(num_vars + 1);
    endfunction

endpackage

// File: rtl/split_eval_acc.sv
// Per-frame running statistics: saturating sum, xor-parity of all bits and an
// all-values-nonzero flag. clear wins over enable.
module split_eval_acc
    import split_pkg::*;
#(
    parameter int VAR_W = 32,
    parameter int ACC_W = 37
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [VAR_W-1:0] data,
    output logic [ACC_W-1:0] acc,
    output logic             parity,
    output logic             nz
);

    logic [ACC_W:0] sum;

    // One guard bit catches the carry so the register pins at all-ones.
    always_comb begin
        sum = {1'b0, acc} + (ACC_W + 1)'(data);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            parity <= 1'b0;
            nz     <= 1'b1;
        end else if (clear) begin
            acc    <= '0;
            parity <= 1'b0;
            nz     <= 1'b1;
        end else if (enable) begin
            acc    <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
            parity <= parity ^ (^data);
            nz     <= nz & (|data);
        end
    end

endmodule

// File: rtl/split_eval_stream.sv
// Streaming split-constraint evaluator: one variable per input beat, one
// verdict per frame, constraint chosen by MODE.
module split_eval_stream
    import split_pkg::*;
#(
    parameter int NUM_VARS = 20,
    parameter int VAR_W    = 32,
    parameter int MODE     = MODE_TRUE,
    parameter logic [acc_width(NUM_VARS, VAR_W)-1:0] BOUND = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VAR_W-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_x,
    output logic             out_err
);

    localparam int ACC_W = acc_width(NUM_VARS, VAR_W);
    localparam int IDX_W = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VARS - 1);

    state_t           state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic             err, err_next;
    logic             collect;
    logic             consume;
    logic [ACC_W-1:0] acc;
    logic             parity;
    logic             nz;
    logic             verdict;

    // Handshakes: a beat transfers on a rising edge where valid&ready are both
    // high; valid never waits on ready, and a producer holding valid keeps its
    // payload stable until the transfer.
    assign collect = in_valid & in_ready & ((state == IDLE) | (state == ACC));
    assign consume = out_valid & out_ready;

    split_eval_acc #(
        .VAR_W(VAR_W),
        .ACC_W(ACC_W)
    ) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (consume),
        .enable(collect),
        .data  (in_data),
        .acc   (acc),
        .parity(parity),
        .nz    (nz)
    );

    always_comb begin
        verdict = 1'b1;
        case (MODE)
            MODE_SUM_LE:      verdict = (acc <= BOUND);
            MODE_PARITY_EVEN: verdict = ~parity;
            MODE_ALL_NZ:      verdict = nz;
            default:          verdict = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        err_next   = err;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_x      = 1'b0;
        out_err    = 1'b0;
        case (state)
            IDLE, ACC: begin
                in_ready = rst_n;
                if (in_valid && rst_n) begin
                    idx_next = idx + IDX_W'(1);
                    if (in_last) begin
                        state_next = DONE;
                        if (idx != IDX_LAST) err_next = 1'b1;
                    end else if (idx == IDX_LAST) begin
                        state_next = DRAIN;
                        err_next   = 1'b1;
                    end else begin
                        state_next = ACC;
                    end
                end
            end
            // Overlong frame: swallow the tail so only one verdict is produced.
            DRAIN: begin
                in_ready = rst_n;
                if (in_valid && in_last && rst_n) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                out_x     = verdict & ~err;
                out_err   = err;
                if (out_ready) begin
                    state_next = IDLE;
                    idx_next   = '0;
                    err_next   = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            err   <= err_next;
        end
    end

endmodule
